// File: rtl/i2c_target_pkg.sv
// ============================================================================
// Module : i2c_target_pkg
// Brief  : Shared types and constants for the I2C target model and bus helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_PTR   = 4'd3,
    ST_WR_DATA  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_DATA  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_tgt_state_e;

  localparam logic I2cRwRead  = 1'b1;
  localparam logic I2cRwWrite = 1'b0;
  localparam logic I2cAckBit  = 1'b0;

  localparam logic [3:0] BitsPerByte = 4'd8;

endpackage : i2c_target_pkg

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// Module : i2c_bus_sync
// Brief  : Two-flop SCL/SDA synchronisers with a third flop for edge and
//          START/STOP detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Reset to the idle-bus level so releasing reset never fakes a START/STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  // SCL must be high on both sides of the SDA edge; a coincident SCL edge is a data edge.
  assign start_det =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];
  assign sda_s     =  sda_q[1];

endmodule : i2c_bus_sync

`default_nettype wire

// File: rtl/i2c_target_model.sv
// ============================================================================
// Module : i2c_target_model
// Brief  : Simulation I2C target: 7-bit addressed register file, EEPROM-style
//          pointer/data protocol, open-drain SDA drive and write strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_target_model
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TargetAddr = 7'h50,
  parameter int unsigned NumRegs    = 16,
  parameter logic [7:0]  RegInit    = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe_o,
  output logic                       busy_o,
  output logic                       wr_valid_o,
  output logic [$clog2(NumRegs)-1:0] wr_addr_o,
  output logic [7:0]                 wr_data_o,
  output logic [7:0]                 nack_cnt_o
);

  localparam int PtrW = $clog2(NumRegs);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_bus_sync (
    .clk       (clk_i),
    .rst       (rst_i),
    .scl       (scl_i),
    .sda       (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_e    state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_in_q, shift_in_d;
  logic [6:0]        shift_out_q, shift_out_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_valid_q, wr_valid_d;
  logic [PtrW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        nack_q, nack_d;
  logic              reg_we;
  logic [7:0]        rx_byte;
  logic [7:0]        regs [NumRegs];

  // Byte as it stands once the current SDA sample is shifted in.
  assign rx_byte = {shift_in_q, sda_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      ptr_q       <= '0;
      rw_q        <= I2cRwWrite;
      sda_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      nack_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      nack_q      <= nack_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= RegInit;
    end else if (reg_we) begin
      regs[ptr_q] <= rx_byte;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    nack_d      = nack_q;
    reg_we      = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q < BitsPerByte) begin
            shift_in_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BitsPerByte - 4'd1) begin
              rw_d = sda_s;
              if (shift_in_q != TargetAddr) begin
                if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
                state_d = ST_IGNORE;
              end
            end
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            sda_oe_d = ~I2cAckBit;
            state_d  = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q == I2cRwRead) begin
              shift_out_d = regs[ptr_q][6:0];
              sda_oe_d    = ~regs[ptr_q][7];
              state_d     = ST_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_PTR;
            end
          end
        end
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q < BitsPerByte) begin
            shift_in_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BitsPerByte - 4'd1) begin
              if (state_q == ST_WR_PTR) begin
                ptr_d = rx_byte[PtrW-1:0];
              end else begin
                reg_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + PtrW'(1);
              end
            end
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            sda_oe_d = ~I2cAckBit;
            state_d  = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise && bit_cnt_q < BitsPerByte) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + PtrW'(1);
            state_d  = ST_RD_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            sda_oe_d    = ~shift_out_q[6];
            shift_out_d = {shift_out_q[5:0], 1'b0};
          end
        end
        ST_RD_ACK: begin
          // bit_cnt 9 marks "controller ACKed, next byte starts on this fall".
          if (scl_rise && bit_cnt_q == BitsPerByte) begin
            if (sda_s != I2cAckBit) state_d = ST_IGNORE;
            else                    bit_cnt_d = BitsPerByte + 4'd1;
          end else if (scl_fall && bit_cnt_q == BitsPerByte + 4'd1) begin
            shift_out_d = regs[ptr_q][6:0];
            sda_oe_d    = ~regs[ptr_q][7];
            bit_cnt_d   = '0;
            state_d     = ST_RD_DATA;
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default:   state_d  = ST_IDLE;
      endcase
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign nack_cnt_o = nack_q;

endmodule : i2c_target_model

`default_nettype wire
